// File: rtl/grey_code.sv
// rtl/grey_code.sv - 4-bit binary/Gray converter with registered result and Hamming-distance monitor
module grey_code #(
   parameter logic [3:0] RST_VAL = 4'b0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       D,
   input  logic       mode,
   input  logic       en,
   output logic [3:0] F,
   output logic [3:0] F_q,
   output logic       valid_q,
   output logic [2:0] dist_q
);

   logic [3:0] x;
   logic [3:0] prev;
   logic [3:0] diff;

   assign x = {A, B, C, D};

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   // Gray-to-binary is a running XOR prefix from the MSB down.
   always_comb begin
      F = 4'b0000;
      if (mode) begin
         F[3] = x[3];
         F[2] = x[3] ^ x[2];
         F[1] = x[3] ^ x[2] ^ x[1];
         F[0] = x[3] ^ x[2] ^ x[1] ^ x[0];
      end else begin
         F = x ^ {1'b0, x[3:1]};
      end
   end

   assign diff = F ^ prev;

   // prev survives mode changes, so distance may compare codes across modes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         F_q     <= RST_VAL;
         prev    <= RST_VAL;
         valid_q <= 1'b0;
         dist_q  <= 3'd0;
      end else if (en) begin
         F_q     <= F;
         prev    <= F;
         dist_q  <= popcount4(diff);
         valid_q <= 1'b1;
      end else begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_grey_code.sv
// tb/tb_grey_code.sv - directed self-checking bench for grey_code
module tb_grey_code;

   logic       clk;
   logic       rst_n;
   logic       A, B, C, D;
   logic       mode;
   logic       en;
   logic [3:0] F;
   logic [3:0] F_q;
   logic       valid_q;
   logic [2:0] dist_q;

   int checks;
   int errors;

   logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000};

   grey_code #(.RST_VAL(4'b0000)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A       (A),
      .B       (B),
      .C       (C),
      .D       (D),
      .mode    (mode),
      .en      (en),
      .F       (F),
      .F_q     (F_q),
      .valid_q (valid_q),
      .dist_q  (dist_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_x(input logic [3:0] x);
      {A, B, C, D} = x;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      en    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      mode  = 1'b0;
      set_x(4'b0000);
      #2;
      checks++;
      if (F_q !== 4'b0000) begin errors++; $display("FAIL reset_F_q actual=%b expected=0000", F_q); end
      checks++;
      if (valid_q !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b expected=0", valid_q); end
      checks++;
      if (dist_q !== 3'd0) begin errors++; $display("FAIL reset_dist actual=%0d expected=0", dist_q); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_comb_zero();
      set_x(4'b0000);
      mode = 1'b0;
      #5;
      checks++;
      if (F !== 4'b0000) begin errors++; $display("FAIL comb_zero_m0 actual=%b expected=0000", F); end
      mode = 1'b1;
      #5;
      checks++;
      if (F !== 4'b0000) begin errors++; $display("FAIL comb_zero_m1 actual=%b expected=0000", F); end
   endtask

   task automatic test_bin2gray();
      mode = 1'b0;
      for (int i = 0; i < 16; i++) begin
         set_x(i[3:0]);
         #1;
         checks++;
         if (F !== gray_tab[i]) begin
            errors++;
            $display("FAIL bin2gray x=%0d actual=%b expected=%b", i, F, gray_tab[i]);
         end
      end
   endtask

   task automatic test_round_trip();
      mode = 1'b1;
      for (int i = 0; i < 16; i++) begin
         set_x(gray_tab[i]);
         #1;
         checks++;
         if (F !== i[3:0]) begin
            errors++;
            $display("FAIL round_trip x=%0d actual=%b expected=%b", i, F, i[3:0]);
         end
      end
   endtask

   task automatic test_registered();
      do_reset();
      @(negedge clk);
      mode = 1'b0;
      en   = 1'b1;
      set_x(4'b0011);
      @(posedge clk); #1;
      checks++;
      if (F_q !== 4'b0010) begin errors++; $display("FAIL reg_F_q actual=%b expected=0010", F_q); end
      checks++;
      if (valid_q !== 1'b1) begin errors++; $display("FAIL reg_valid actual=%b expected=1", valid_q); end
      checks++;
      if (dist_q !== 3'd1) begin errors++; $display("FAIL reg_dist actual=%0d expected=1", dist_q); end
      @(negedge clk);
      en = 1'b0;
      set_x(4'b1111);
      @(posedge clk); #1;
      checks++;
      if (F_q !== 4'b0010) begin errors++; $display("FAIL hold_F_q actual=%b expected=0010", F_q); end
      checks++;
      if (valid_q !== 1'b0) begin errors++; $display("FAIL hold_valid actual=%b expected=0", valid_q); end
      checks++;
      if (dist_q !== 3'd1) begin errors++; $display("FAIL hold_dist actual=%0d expected=1", dist_q); end
      // Mode switch: X=1111 in mode 1 -> 1010, prev 0010 differs in one bit
      @(negedge clk);
      mode = 1'b1;
      en   = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (F_q !== 4'b1010) begin errors++; $display("FAIL xmode_F_q actual=%b expected=1010", F_q); end
      checks++;
      if (dist_q !== 3'd1) begin errors++; $display("FAIL xmode_dist actual=%0d expected=1", dist_q); end
   endtask

   task automatic test_max_distance();
      do_reset();
      @(negedge clk);
      mode = 1'b0;
      en   = 1'b1;
      set_x(4'b1010);
      @(posedge clk); #1;
      checks++;
      if (F_q !== 4'b1111) begin errors++; $display("FAIL maxd_F_q actual=%b expected=1111", F_q); end
      checks++;
      if (dist_q !== 3'd4) begin errors++; $display("FAIL maxd_dist actual=%0d expected=4", dist_q); end
   endtask

   task automatic test_counting();
      do_reset();
      mode = 1'b0;
      for (int n = 0; n <= 16; n++) begin
         @(negedge clk);
         en = 1'b1;
         set_x(n[3:0]);
         @(posedge clk); #1;
         checks++;
         if (F_q !== gray_tab[n % 16]) begin
            errors++;
            $display("FAIL count_F_q n=%0d actual=%b expected=%b", n, F_q, gray_tab[n % 16]);
         end
         checks++;
         if (dist_q !== ((n == 0) ? 3'd0 : 3'd1)) begin
            errors++;
            $display("FAIL count_dist n=%0d actual=%0d expected=%0d", n, dist_q, (n == 0) ? 0 : 1);
         end
         checks++;
         if (valid_q !== 1'b1) begin
            errors++;
            $display("FAIL count_valid n=%0d actual=%b expected=1", n, valid_q);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      mode = 1'b0;
      en   = 1'b1;
      set_x(4'b0111);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (F_q !== 4'b0000) begin errors++; $display("FAIL async_F_q actual=%b expected=0000", F_q); end
      checks++;
      if (valid_q !== 1'b0) begin errors++; $display("FAIL async_valid actual=%b expected=0", valid_q); end
      checks++;
      if (dist_q !== 3'd0) begin errors++; $display("FAIL async_dist actual=%0d expected=0", dist_q); end
      set_x(4'b0110);
      #1;
      checks++;
      if (F !== 4'b0101) begin errors++; $display("FAIL async_F_comb actual=%b expected=0101", F); end
      @(posedge clk); #1;
      checks++;
      if (F_q !== 4'b0000) begin errors++; $display("FAIL async_held actual=%b expected=0000", F_q); end
      @(negedge clk);
      rst_n = 1'b1;
      set_x(4'b0001);
      @(posedge clk); #1;
      checks++;
      if (dist_q !== 3'd1) begin errors++; $display("FAIL post_reset_dist actual=%0d expected=1", dist_q); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      en     = 1'b0;
      mode   = 1'b0;
      set_x(4'b0000);
      test_reset();
      test_comb_zero();
      test_bin2gray();
      test_round_trip();
      test_registered();
      test_max_distance();
      test_counting();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/grey_code.md
Name: grey_code

Overview:
- 4-bit binary/Gray code converter with a combinational result and a registered result.
- Input word is {A,B,C,D}, with A as the MSB.
- F is the zero-latency conversion.
- F_q, valid_q and dist_q are registered copies plus a Hamming-distance monitor, for downstream counters and encoders that need a clean registered code.

Parameters:
- RST_VAL, 4'b0000, value loaded into F_q and the previous-code register on reset.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- A  in  1  input bit 3 (MSB).
- B  in  1  input bit 2.
- C  in  1  input bit 1.
- D  in  1  input bit 0 (LSB).
- mode  in  1  0 = binary-to-Gray, 1 = Gray-to-binary.
- en  in  1  capture enable for the registered outputs.
- F  out  4  combinational conversion of {A,B,C,D}.
- F_q  out  4  registered conversion result.
- valid_q  out  1  high for one cycle after each capture.
- dist_q  out  3  Hamming distance between the last two captured F values (0..4).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Let X = {A,B,C,D}.
- mode=0 (binary-to-Gray):
  - F[3] = A
  - F[2] = A^B
  - F[1] = B^C
  - F[0] = C^D
- mode=1 (Gray-to-binary):
  - F[3] = A
  - F[2] = A^B
  - F[1] = A^B^C
  - F[0] = A^B^C^D
- F is purely combinational: no clock dependency, valid during reset, settles within the same delta/timestep as an input change.
- Example: X=0000 gives F=0000 in both modes.
- Reset (rst_n=0, asynchronous): F_q=RST_VAL, previous-code register prev=RST_VAL, valid_q=0, dist_q=0. Held while rst_n is low.
- Rising clk with en=1:
  - F_q <= F
  - prev <= F
  - dist_q <= popcount(F ^ prev)
  - valid_q <= 1
- Rising clk with en=0: F_q, prev and dist_q hold; valid_q <= 0.
- Latency: F is 0 cycles. F_q, valid_q and dist_q reflect inputs sampled 1 cycle earlier.
- Mode change takes effect immediately on F and on the next capture for F_q. prev is not cleared, so dist_q after a mode switch compares codes across modes.
- Reset asserted mid-operation clears all registers immediately. The first capture after reset compares against RST_VAL.
- Consecutive captures of binary inputs n and n+1 (mod 16, including the 1111->0000 wrap) in mode 0 must yield dist_q=1.
- Round trip: converting Gray(X) back with mode=1 returns X for all 16 values.

Test Plan:
- Combinational zero: X=0000 in both modes, no clock -> F=0000 after 5 ns (each bit F[3..0]=0).
- Exhaustive mode 0 table: X=0..15 -> F = X^(X>>1), e.g. 0101 -> 0111, 1111 -> 1000, 1000 -> 1100.
- Round trip: for each X, drive Gray(X) with mode=1 -> F=X, e.g. 0111 -> 0101.
- Registered path: rst_n=0 then release, en=1, X=0011 mode 0 -> next edge F_q=0010, valid_q=1, dist_q=1. Then en=0 -> F_q holds and valid_q=0.
- Counting sequence: mode 0, X increments 0..15 then wraps to 0, en=1 each cycle -> dist_q=1 on every capture after the first. The first capture after reset with X=0 gives dist_q=0.
- Async reset mid-run: assert rst_n low between clock edges -> F_q=0000, valid_q=0, dist_q=0 immediately. F still tracks X combinationally.
